// File: rtl/apb_i2c_regs_fifo.sv
// APB3 register front end for the I2C core with TX/RX byte FIFOs and W1C interrupts.
// Define APB_I2C_PSLVERR_EN to drive PSLVERR on erroneous accesses; otherwise it is tied low.
module apb_i2c_regs_fifo #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TOUT_W   = 20
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [11:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              PINT,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [8:0]        tx_addr,
  output logic [7:0]        tx_cnt,
  output logic [15:0]       ctrl,
  output logic [TOUT_W-1:0] time_out,
  input  logic [7:0]        status,
  input  logic              error,
  output logic              i2c_ready
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);

  logic [8:0]        r_addr;
  logic [7:0]        r_cnt;
  logic [15:0]       r_ctrl;
  logic [4:0]        r_ier;
  logic [4:0]        r_isr;
  logic [TOUT_W-1:0] r_tout;
  logic              r_i2c_ready;
  logic              r_pint;
  logic [31:0]       r_prdata;
  logic              r_rd_err;
  logic              r_stat1_d;
  logic              r_error_d;

  logic [7:0]        r_tx_mem [TX_DEPTH];
  logic [TPW-1:0]    r_tx_wptr, r_tx_rptr;
  logic [TPW:0]      r_tx_level;
  logic [7:0]        r_rx_mem [RX_DEPTH];
  logic [RPW-1:0]    r_rx_wptr, r_rx_rptr;
  logic [RPW:0]      r_rx_level;

  logic [5:0]        w_idx;
  logic              w_setup, w_wr, w_rd_acc, w_wr_ok;
  logic              w_wr_err, w_rd_err;
  logic [31:0]       w_rdata;
  logic              w_flush;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_ovf;
  logic [TPW:0]      w_tx_lvl_nxt;
  logic [RPW:0]      w_rx_lvl_nxt;
  logic [7:0]        w_rx_head;
  logic [4:0]        w_isr_set, w_isr_clr;
  logic              w_unused;

  assign w_unused = ^{PADDR, PWDATA};

  assign w_idx    = PADDR[7:2];
  assign w_setup  = PSEL & ~PENABLE;
  assign w_wr     = PSEL & PENABLE & PWRITE;
  assign w_rd_acc = PSEL & PENABLE & ~PWRITE;

  assign w_tx_full  = (r_tx_level == (TPW+1)'(TX_DEPTH));
  assign w_tx_empty = (r_tx_level == '0);
  assign w_rx_full  = (r_rx_level == (RPW+1)'(RX_DEPTH));
  assign w_rx_empty = (r_rx_level == '0);
  assign w_rx_head  = r_rx_mem[r_rx_rptr];

  always_comb begin
    w_wr_err = 1'b0;
    case (w_idx)
      6'd0, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8: w_wr_err = 1'b0;
      6'd2:    w_wr_err = w_tx_full;
      default: w_wr_err = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_err = 1'b0;
    case (w_idx)
      6'd0, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: w_rd_err = 1'b0;
      6'd3:    w_rd_err = w_rx_empty;
      default: w_rd_err = 1'b1;
    endcase
  end

  // The flush strobe bit is write-only in effect; it always reads back as 0.
  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      6'd0: w_rdata = {23'h0, r_addr};
      6'd1: w_rdata = {24'h0, status};
      6'd3: w_rdata = {24'h0, w_rx_head};
      6'd4: w_rdata = {24'h0, r_cnt};
      6'd5: w_rdata = {17'h0, r_ctrl[14:0]};
      6'd6: w_rdata = {27'h0, r_ier};
      6'd7: w_rdata = {27'h0, r_isr};
      6'd8: w_rdata = 32'(r_tout);
      6'd9: w_rdata = {14'h0, w_rx_empty, w_tx_full, 8'(r_rx_level), 8'(r_tx_level)};
      default: w_rdata = 32'h0;
    endcase
  end

  assign w_wr_ok = w_wr & ~w_wr_err;
  // Flush acts on the committing write so the very next transfer already sees empty FIFOs.
  assign w_flush = w_wr_ok & (w_idx == 6'd5) & PWDATA[15];

  assign w_tx_push = w_wr_ok & (w_idx == 6'd2) & ~w_flush;
  assign w_tx_pop  = ~w_tx_empty & tx_ready & ~w_flush;
  assign w_rx_push = rx_valid & ~w_rx_full & ~w_flush;
  assign w_rx_ovf  = rx_valid & w_rx_full & ~w_flush;
  assign w_rx_pop  = w_rd_acc & (w_idx == 6'd3) & ~r_rd_err & ~w_rx_empty & ~w_flush;

  always_comb begin
    w_tx_lvl_nxt = r_tx_level;
    if (w_flush)                     w_tx_lvl_nxt = '0;
    else if (w_tx_push && !w_tx_pop) w_tx_lvl_nxt = r_tx_level + 1'b1;
    else if (w_tx_pop && !w_tx_push) w_tx_lvl_nxt = r_tx_level - 1'b1;
  end

  always_comb begin
    w_rx_lvl_nxt = r_rx_level;
    if (w_flush)                     w_rx_lvl_nxt = '0;
    else if (w_rx_push && !w_rx_pop) w_rx_lvl_nxt = r_rx_level + 1'b1;
    else if (w_rx_pop && !w_rx_push) w_rx_lvl_nxt = r_rx_level - 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_level <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_level <= '0;
    end else begin
      r_tx_level <= w_tx_lvl_nxt;
      r_rx_level <= w_rx_lvl_nxt;
      if (w_flush) begin
        r_tx_wptr <= '0;
        r_tx_rptr <= '0;
        r_rx_wptr <= '0;
        r_rx_rptr <= '0;
      end else begin
        if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
        if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
        if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
        if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= PWDATA[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
  end

  assign w_isr_set = {w_rx_ovf,
                      error & ~r_error_d,
                      w_rx_empty & (w_rx_lvl_nxt != '0),
                      ~w_tx_empty & (w_tx_lvl_nxt == '0),
                      status[1] & ~r_stat1_d};
  assign w_isr_clr = (w_wr_ok && w_idx == 6'd7) ? PWDATA[4:0] : 5'h0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_ctrl      <= '0;
      r_ier       <= '0;
      r_isr       <= '0;
      r_tout      <= '0;
      r_i2c_ready <= 1'b0;
      r_pint      <= 1'b0;
      r_prdata    <= '0;
      r_rd_err    <= 1'b0;
      r_stat1_d   <= 1'b0;
      r_error_d   <= 1'b0;
    end else begin
      r_stat1_d <= status[1];
      r_error_d <= error;
      r_isr     <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_pint    <= |(r_isr & r_ier);

      if (w_setup && !PWRITE) begin
        r_prdata <= w_rd_err ? 32'h0 : w_rdata;
        r_rd_err <= w_rd_err;
      end

      if (w_wr_ok && w_idx == 6'd5) r_ctrl <= PWDATA[15:0];
      else                          r_ctrl[15] <= 1'b0;

      if (w_wr_ok) begin
        case (w_idx)
          6'd0:    r_addr <= PWDATA[8:0];
          6'd4:    r_cnt  <= PWDATA[7:0];
          6'd6:    r_ier  <= PWDATA[4:0];
          6'd8:    r_tout <= PWDATA[TOUT_W-1:0];
          default: ;
        endcase
      end

      if (status[1])                                  r_i2c_ready <= 1'b0;
      else if (w_wr_ok && w_idx == 6'd5 && PWDATA[11]) r_i2c_ready <= 1'b1;
    end
  end

  assign PRDATA    = r_prdata;
  assign PREADY    = 1'b1;
  assign PINT      = r_pint;
  assign tx_valid  = ~w_tx_empty;
  assign tx_data   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
  assign tx_addr   = r_addr;
  assign tx_cnt    = r_cnt;
  assign ctrl      = r_ctrl;
  assign time_out  = r_tout;
  assign i2c_ready = r_i2c_ready;

`ifdef APB_I2C_PSLVERR_EN
  assign PSLVERR = PSEL & PENABLE & (PWRITE ? w_wr_err : r_rd_err);
`else
  assign PSLVERR = 1'b0;
`endif

endmodule
